// File: rtl/phos_fec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phos_fec_pkg                                                               |
// | Shared constants, command codes and DAC word layout for the PHOS FEC core. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package phos_fec_pkg;

    localparam int N_DAC      = 4;
    localparam int CH_PER_DAC = 8;
    localparam int N_CH       = N_DAC * CH_PER_DAC;
    localparam int DAC_W      = $clog2(N_DAC);
    localparam int REPLY_LEN  = 65;

    localparam logic [7:0] HV_BASE        = 8'h60;
    localparam logic [7:0] HV_UPDATE_ADDR = 8'h1E;
    localparam logic [7:0] STATUS_ADDR    = 8'h1F;

    typedef enum logic [7:0] {
        CMD_SLOW     = 8'hE1,
        CMD_RDO      = 8'hE2,
        CMD_SCLKSYNC = 8'hE4,
        CMD_RST      = 8'hE8,
        CMD_STREQ    = 8'hE9,
        CMD_REJECT   = 8'hEA,
        CMD_ARDOEND  = 8'hEF
    } cmd_e;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_HDR     = 2'd1,
        RX_PAYLOAD = 2'd2,
        RX_WAIT0   = 2'd3
    } rx_state_e;

    typedef enum logic [2:0] {
        SPI_IDLE       = 3'd0,
        SPI_WORD_START = 3'd1,
        SPI_SHIFT_LO   = 3'd2,
        SPI_SHIFT_HI   = 3'd3,
        SPI_GAP        = 3'd4,
        SPI_LDAC       = 3'd5
    } spi_state_e;

    function automatic logic [15:0] dac_word(input logic [2:0] ch, input logic [7:0] value);
        return {1'b0, ch, value, 4'h0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/phos_fec_hv_dac_spi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phos_fec_hv_dac_spi                                                        |
// | Word-level SPI shifter for the HV DACs plus the LDAC load pulse.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phos_fec_hv_dac_spi
    import phos_fec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_word_start,
    input  logic [15:0]      i_word_data,
    input  logic [DAC_W-1:0] i_word_dac,
    input  logic             i_ldac_start,
    output logic             o_ready,
    output logic             o_ldac_done,
    output logic             o_sclk,
    output logic             o_din,
    output logic [N_DAC-1:0] o_sync_b,
    output logic             o_ldac_b
);

    spi_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      shreg_q, shreg_d;
    logic [DAC_W-1:0] dac_q, dac_d;
    logic             sclk_q, sclk_d;
    logic             din_q, din_d;
    logic [N_DAC-1:0] sync_b_q, sync_b_d;
    logic             ldac_b_q, ldac_b_d;
    logic             w_framing;

    // A new word or the LDAC pulse may launch on the last gap cycle, keeping words back to back.
    assign o_ready     = (state_q == SPI_IDLE) || ((state_q == SPI_GAP) && (cnt_q == 4'd0));
    assign o_ldac_done = (state_q == SPI_LDAC) && (cnt_q == 4'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        dac_d    = dac_q;
        case (state_q)
            SPI_IDLE: ;
            SPI_WORD_START: begin
                state_d = SPI_SHIFT_LO;
                cnt_d   = 4'd15;
            end
            SPI_SHIFT_LO: begin
                state_d = SPI_SHIFT_HI;
                shreg_d = {shreg_q[14:0], 1'b0};
            end
            SPI_SHIFT_HI: begin
                if (cnt_q == 4'd0) begin
                    state_d = SPI_GAP;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = SPI_SHIFT_LO;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            SPI_GAP, SPI_LDAC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = SPI_IDLE;
                end
            end
            default: state_d = SPI_IDLE;
        endcase

        if (o_ready) begin
            if (i_word_start) begin
                state_d = SPI_WORD_START;
                shreg_d = i_word_data;
                dac_d   = i_word_dac;
            end else if (i_ldac_start) begin
                state_d = SPI_LDAC;
                cnt_d   = 4'd1;
            end
        end

        // Pins are registered from the next state so they change glitch-free with the FSM.
        w_framing = (state_d == SPI_WORD_START) || (state_d == SPI_SHIFT_LO) ||
                    (state_d == SPI_SHIFT_HI);
        sclk_d    = (state_d != SPI_SHIFT_LO);
        din_d     = w_framing ? shreg_d[15] : 1'b0;
        sync_b_d  = '1;
        if (w_framing) begin
            sync_b_d[dac_d] = 1'b0;
        end
        ldac_b_d  = (state_d != SPI_LDAC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SPI_IDLE;
            cnt_q    <= 4'd0;
            shreg_q  <= 16'h0;
            dac_q    <= '0;
            sclk_q   <= 1'b1;
            din_q    <= 1'b0;
            sync_b_q <= '1;
            ldac_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            dac_q    <= dac_d;
            sclk_q   <= sclk_d;
            din_q    <= din_d;
            sync_b_q <= sync_b_d;
            ldac_b_q <= ldac_b_d;
        end
    end

    assign o_sclk   = sclk_q;
    assign o_din    = din_q;
    assign o_sync_b = sync_b_q;
    assign o_ldac_b = ldac_b_q;

endmodule

`default_nettype wire

// File: rtl/phos_fec_v1_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phos_fec_v1_top                                                            |
// | DTC slow-control core: command receiver, HV register bank, read replies    |
// | and the HV DAC update sequencer.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phos_fec_v1_top
    import phos_fec_pkg::*;
(
    input  logic       dtc_clk,
    input  logic       rst_n,
    input  logic       dtc_trig,
    output logic       dtc_return,
    output logic       fast_cmd_valid,
    output logic [7:0] fast_cmd,
    output logic       hv_dac_sclk,
    output logic       hv_dac_din,
    output logic [3:0] hv_dac_sync_b,
    output logic       hv_dac_ldac_b,
    output logic       hv_busy
);

    rx_state_e   rx_state_q, rx_state_d;
    logic [6:0]  rx_cnt_q, rx_cnt_d;
    logic [6:0]  hdr_q, hdr_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        slow_valid_q, slow_valid_d;
    logic        fast_cmd_valid_q, fast_cmd_valid_d;
    logic [7:0]  fast_cmd_q, fast_cmd_d;
    logic [7:0]  hv_q [N_CH];
    logic [7:0]  hv_d [N_CH];
    logic [64:0] reply_sr_q, reply_sr_d;
    logic [6:0]  reply_cnt_q, reply_cnt_d;
    logic        busy_q, busy_d;
    logic [5:0]  word_idx_q, word_idx_d;

    logic [7:0]  w_header;
    logic        w_is_read, w_is_write, w_hv_sel, w_hv_write, w_update_req;
    logic [4:0]  w_ch;
    logic [31:0] w_rdata;
    logic        w_word_start, w_ldac_start, w_spi_ready, w_spi_ldac_done;
    logic [4:0]  w_launch_idx;
    logic [15:0] w_word;

    // Command receiver
    always_comb begin
        rx_state_d       = rx_state_q;
        rx_cnt_d         = rx_cnt_q;
        hdr_d            = hdr_q;
        addr_d           = addr_q;
        data_d           = data_q;
        slow_valid_d     = 1'b0;
        fast_cmd_valid_d = 1'b0;
        fast_cmd_d       = fast_cmd_q;
        w_header         = {hdr_q, dtc_trig};
        case (rx_state_q)
            RX_IDLE: begin
                if (dtc_trig) begin
                    hdr_d      = 7'd1;
                    rx_cnt_d   = 7'd1;
                    rx_state_d = RX_HDR;
                end
            end
            RX_HDR: begin
                hdr_d    = {hdr_q[5:0], dtc_trig};
                rx_cnt_d = rx_cnt_q + 7'd1;
                if (rx_cnt_q == 7'd7) begin
                    rx_cnt_d = 7'd0;
                    if (w_header == CMD_SLOW) begin
                        rx_state_d = RX_PAYLOAD;
                    end else begin
                        rx_state_d = RX_WAIT0;
                        if (w_header[7:4] == 4'hE) begin
                            fast_cmd_valid_d = 1'b1;
                            fast_cmd_d       = w_header;
                        end
                    end
                end
            end
            RX_PAYLOAD: begin
                rx_cnt_d = rx_cnt_q + 7'd1;
                // Only data[7:0] is ever stored, so the data field is kept in a byte shifter.
                if (rx_cnt_q < 7'd32) begin
                    addr_d = {addr_q[30:0], dtc_trig};
                end else begin
                    data_d = {data_q[6:0], dtc_trig};
                end
                if (rx_cnt_q == 7'd63) begin
                    slow_valid_d = 1'b1;
                    rx_state_d   = RX_WAIT0;
                end
            end
            RX_WAIT0: begin
                if (!dtc_trig) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Slow command decode; HV_BASE is 32-aligned so the low address bits pick the channel.
    assign w_is_read    = slow_valid_q && addr_q[31];
    assign w_is_write   = slow_valid_q && !addr_q[31] && (addr_q[30:8] == 23'd0);
    assign w_hv_sel     = (addr_q[7:5] == HV_BASE[7:5]);
    assign w_ch         = addr_q[4:0];
    assign w_hv_write   = w_is_write && w_hv_sel;
    assign w_update_req = w_is_write && (addr_q[7:0] == HV_UPDATE_ADDR);

    always_comb begin
        w_rdata = 32'h0;
        if (w_hv_sel) begin
            w_rdata = {24'h0, hv_q[w_ch]};
        end else if (addr_q[7:0] == STATUS_ADDR) begin
            w_rdata = {31'h0, busy_q};
        end
    end

    always_comb begin
        hv_d = hv_q;
        if (fast_cmd_valid_q && (fast_cmd_q == CMD_RST)) begin
            for (int i = 0; i < N_CH; i++) begin
                hv_d[i] = 8'h0;
            end
        end else if (w_hv_write) begin
            hv_d[w_ch] = data_q;
        end
    end

    always_comb begin
        reply_sr_d  = {reply_sr_q[63:0], 1'b0};
        reply_cnt_d = (reply_cnt_q == 7'd0) ? 7'd0 : reply_cnt_q - 7'd1;
        if (w_is_read && (reply_cnt_q == 7'd0)) begin
            reply_sr_d  = {1'b1, addr_q, w_rdata};
            reply_cnt_d = 7'(REPLY_LEN);
        end
    end

    // Update sequencer: feeds the SPI shifter one word per slot, then requests LDAC.
    always_comb begin
        busy_d       = busy_q;
        word_idx_d   = word_idx_q;
        w_word_start = 1'b0;
        w_ldac_start = 1'b0;
        if (!busy_q) begin
            if (w_update_req) begin
                busy_d       = 1'b1;
                w_word_start = 1'b1;
                word_idx_d   = 6'd1;
            end
        end else if (w_spi_ldac_done) begin
            busy_d = 1'b0;
        end else if (w_spi_ready) begin
            if (word_idx_q == 6'(N_CH)) begin
                w_ldac_start = 1'b1;
            end else begin
                w_word_start = 1'b1;
                word_idx_d   = word_idx_q + 6'd1;
            end
        end
        w_launch_idx = busy_q ? word_idx_q[4:0] : 5'd0;
        w_word       = dac_word(w_launch_idx[2:0], hv_q[w_launch_idx]);
    end

    always_ff @(posedge dtc_clk) begin
        if (!rst_n) begin
            rx_state_q       <= RX_IDLE;
            rx_cnt_q         <= 7'd0;
            hdr_q            <= 7'd0;
            addr_q           <= 32'h0;
            data_q           <= 8'h0;
            slow_valid_q     <= 1'b0;
            fast_cmd_valid_q <= 1'b0;
            fast_cmd_q       <= 8'h0;
            for (int i = 0; i < N_CH; i++) begin
                hv_q[i] <= 8'h0;
            end
            reply_sr_q       <= 65'h0;
            reply_cnt_q      <= 7'd0;
            busy_q           <= 1'b0;
            word_idx_q       <= 6'd0;
        end else begin
            rx_state_q       <= rx_state_d;
            rx_cnt_q         <= rx_cnt_d;
            hdr_q            <= hdr_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            slow_valid_q     <= slow_valid_d;
            fast_cmd_valid_q <= fast_cmd_valid_d;
            fast_cmd_q       <= fast_cmd_d;
            hv_q             <= hv_d;
            reply_sr_q       <= reply_sr_d;
            reply_cnt_q      <= reply_cnt_d;
            busy_q           <= busy_d;
            word_idx_q       <= word_idx_d;
        end
    end

    phos_fec_hv_dac_spi u_spi (
        .clk          (dtc_clk),
        .rst_n        (rst_n),
        .i_word_start (w_word_start),
        .i_word_data  (w_word),
        .i_word_dac   (w_launch_idx[4:3]),
        .i_ldac_start (w_ldac_start),
        .o_ready      (w_spi_ready),
        .o_ldac_done  (w_spi_ldac_done),
        .o_sclk       (hv_dac_sclk),
        .o_din        (hv_dac_din),
        .o_sync_b     (hv_dac_sync_b),
        .o_ldac_b     (hv_dac_ldac_b)
    );

    assign dtc_return     = reply_sr_q[64];
    assign fast_cmd_valid = fast_cmd_valid_q;
    assign fast_cmd       = fast_cmd_q;
    assign hv_busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_phos_fec_v1_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_phos_fec_v1_top                                                         |
// | Directed self-checking bench for the PHOS FEC v1 slow-control core.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_phos_fec_v1_top;

    logic       dtc_clk;
    logic       rst_n;
    logic       dtc_trig;
    logic       dtc_return;
    logic       fast_cmd_valid;
    logic [7:0] fast_cmd;
    logic       hv_dac_sclk;
    logic       hv_dac_din;
    logic [3:0] hv_dac_sync_b;
    logic       hv_dac_ldac_b;
    logic       hv_busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_words [32];

    typedef struct packed {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [11];

    phos_fec_v1_top dut (
        .dtc_clk        (dtc_clk),
        .rst_n          (rst_n),
        .dtc_trig       (dtc_trig),
        .dtc_return     (dtc_return),
        .fast_cmd_valid (fast_cmd_valid),
        .fast_cmd       (fast_cmd),
        .hv_dac_sclk    (hv_dac_sclk),
        .hv_dac_din     (hv_dac_din),
        .hv_dac_sync_b  (hv_dac_sync_b),
        .hv_dac_ldac_b  (hv_dac_ldac_b),
        .hv_busy        (hv_busy)
    );

    initial begin
        dtc_clk = 1'b0;
        forever #5 dtc_clk = ~dtc_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [71:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge dtc_clk);
            dtc_trig = v[i];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge dtc_clk);
            dtc_trig = 1'b0;
        end
    endtask

    task automatic slow_write(input logic [31:0] addr, input logic [31:0] data);
        send_bits({8'hE1, addr, data}, 72);
        idle(3);
    endtask

    task automatic slow_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [63:0] frame;
        int          lat;
        frame = 64'h0;
        lat   = 0;
        send_bits({8'hE1, addr, 32'h0}, 72);
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge dtc_clk);
            dtc_trig = 1'b0;
            if (dtc_return === 1'b1) lat = k;
        end
        check({name, "_latency"}, lat, 2);
        if (lat != 0) begin
            for (int i = 63; i >= 0; i--) begin
                @(negedge dtc_clk);
                frame[i] = dtc_return;
            end
        end
        check({name, "_addr_echo"}, frame[63:32], addr);
        check({name, "_data"}, frame[31:0], exp);
        @(negedge dtc_clk);
        check({name, "_return_idle"}, dtc_return, 1'b0);
        idle(2);
    endtask

    // Walks all 32 words cycle by cycle starting at the first word's cycle 0.
    task automatic run_update_checker();
        for (int w = 0; w < 32; w++) begin
            logic [3:0]  m;
            logic [15:0] got;
            int          bad;
            m = 4'hF;
            m[w / 8] = 1'b0;
            got = 16'h0;
            bad = 0;
            if (hv_dac_sync_b !== m || hv_dac_sclk !== 1'b1 || hv_dac_ldac_b !== 1'b1 ||
                hv_busy !== 1'b1) bad++;
            for (int b = 15; b >= 0; b--) begin
                @(negedge dtc_clk);
                if (hv_dac_sync_b !== m || hv_dac_sclk !== 1'b0) bad++;
                got[b] = hv_dac_din;
                @(negedge dtc_clk);
                if (hv_dac_sync_b !== m || hv_dac_sclk !== 1'b1) bad++;
            end
            repeat (2) begin
                @(negedge dtc_clk);
                if (hv_dac_sync_b !== 4'hF || hv_dac_sclk !== 1'b1 || hv_dac_ldac_b !== 1'b1) bad++;
            end
            check($sformatf("spi_protocol_w%0d", w), bad, 0);
            check($sformatf("spi_word_w%0d", w), got, exp_words[w]);
            @(negedge dtc_clk);
        end
        check("ldac_low_1", {hv_dac_ldac_b, hv_busy}, 2'b01);
        @(negedge dtc_clk);
        check("ldac_low_2", {hv_dac_ldac_b, hv_busy}, 2'b01);
        @(negedge dtc_clk);
        check("ldac_release_busy_low", {hv_dac_ldac_b, hv_busy}, 2'b10);
    endtask

    initial begin
        int n_pulses;

        vecs[0]  = '{1'b0, 32'h0000_0060, 32'h0000_0033};
        vecs[1]  = '{1'b0, 32'h0000_0061, 32'h0000_0077};
        vecs[2]  = '{1'b0, 32'h0000_0062, 32'h0000_0099};
        vecs[3]  = '{1'b0, 32'h0000_0071, 32'h0000_00F0};
        vecs[4]  = '{1'b1, 32'h8000_0060, 32'h0000_0033};
        vecs[5]  = '{1'b1, 32'h8000_0071, 32'h0000_00F0};
        vecs[6]  = '{1'b1, 32'h8000_0061, 32'h0000_0077};
        vecs[7]  = '{1'b1, 32'h8000_001F, 32'h0000_0000};
        vecs[8]  = '{1'b1, 32'h8000_0040, 32'h0000_0000};
        vecs[9]  = '{1'b0, 32'h0000_0005, 32'h0000_00AB};
        vecs[10] = '{1'b1, 32'h8000_0005, 32'h0000_0000};

        for (int i = 0; i < 32; i++) begin
            logic [2:0] c;
            c = 3'(i % 8);
            exp_words[i] = {1'b0, c, 12'h000};
        end
        exp_words[0]  = 16'h0330;
        exp_words[1]  = 16'h1770;
        exp_words[2]  = 16'h2990;
        exp_words[17] = 16'h1F00;
        exp_words[31] = 16'h7A50;

        rst_n    = 1'b0;
        dtc_trig = 1'b0;
        repeat (3) @(negedge dtc_clk);
        check("reset_dtc_return", dtc_return, 1'b0);
        check("reset_fast_cmd_valid", fast_cmd_valid, 1'b0);
        check("reset_fast_cmd", fast_cmd, 8'h00);
        check("reset_sclk", hv_dac_sclk, 1'b1);
        check("reset_din", hv_dac_din, 1'b0);
        check("reset_sync_b", hv_dac_sync_b, 4'hF);
        check("reset_ldac_b", hv_dac_ldac_b, 1'b1);
        check("reset_busy", hv_busy, 1'b0);
        rst_n = 1'b1;
        idle(3);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_read) slow_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
            else slow_write(vecs[i].addr, vecs[i].data);
        end

        // Update with concurrent traffic: a second trigger, late register writes, a status read.
        send_bits({8'hE1, 32'h0000_001E, 32'h0}, 72);
        @(negedge dtc_clk);
        dtc_trig = 1'b0;
        check("busy_before_start", hv_busy, 1'b0);
        fork
            begin
                @(negedge dtc_clk);
                run_update_checker();
            end
            begin
                idle(100);
                slow_write(32'h0000_001E, 32'h0);
                slow_write(32'h0000_0060, 32'h44);
                slow_write(32'h0000_007F, 32'hA5);
                slow_read(32'h8000_001F, 32'h1, "status_busy");
            end
        join
        idle(3);
        slow_read(32'h8000_0060, 32'h44, "rd60_after_update");
        slow_read(32'h8000_007F, 32'hA5, "rd7f_after_update");
        slow_read(32'h8000_001F, 32'h0, "status_idle");

        send_bits(72'hE2, 8);
        @(negedge dtc_clk);
        dtc_trig = 1'b0;
        check("fast_e2_valid", fast_cmd_valid, 1'b1);
        check("fast_e2_code", fast_cmd, 8'hE2);
        @(negedge dtc_clk);
        check("fast_e2_one_cycle", fast_cmd_valid, 1'b0);
        idle(3);
        slow_read(32'h8000_0060, 32'h44, "rd60_after_e2");

        @(negedge dtc_clk);
        dtc_trig = 1'b1;
        n_pulses = 0;
        repeat (16) begin
            @(negedge dtc_clk);
            dtc_trig = 1'b0;
            if (fast_cmd_valid === 1'b1) n_pulses++;
        end
        check("l0_no_fast_cmd", n_pulses, 0);
        slow_read(32'h8000_0060, 32'h44, "rd60_after_l0");
        slow_write(32'h0000_0065, 32'h12);
        slow_read(32'h8000_0065, 32'h12, "rd65_after_l0");

        send_bits(72'hE8, 8);
        @(negedge dtc_clk);
        dtc_trig = 1'b0;
        check("fast_e8_valid", {fast_cmd_valid, fast_cmd}, {1'b1, 8'hE8});
        idle(3);
        slow_read(32'h8000_0060, 32'h0, "rd60_after_rst");
        slow_read(32'h8000_0065, 32'h0, "rd65_after_rst");

        // Reset in the middle of a DAC word.
        slow_write(32'h0000_0061, 32'h5C);
        slow_write(32'h0000_001E, 32'h0);
        idle(20);
        check("pre_reset_busy_sync", {hv_busy, hv_dac_sync_b}, {1'b1, 4'hE});
        rst_n = 1'b0;
        @(negedge dtc_clk);
        check("midword_reset_sync_b", hv_dac_sync_b, 4'hF);
        check("midword_reset_sclk", hv_dac_sclk, 1'b1);
        check("midword_reset_busy", hv_busy, 1'b0);
        rst_n = 1'b1;
        idle(3);
        slow_read(32'h8000_0061, 32'h0, "rd61_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
